// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N-input, WIDTH-bit stream multiplexer with valid/ready handshakes.
//   The arbiter is either fixed priority (lowest index wins) or round-robin.
//   A grant is held from the first beat of a packet until its last beat.
//   The output beat is registered, so it takes one cycle from accept to
//   out_valid. in_ready is combinational from in_valid and out_ready.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   mode       0 = fixed priority, 1 = round-robin (sampled when arbitrating)
//   in_data    channel k occupies bits [k*WIDTH +: WIDTH]
//   in_valid   per-channel beat valid
//   in_last    per-channel end-of-packet, qualified by in_valid
//   in_ready   per-channel accept, at most one bit set
//   out_data   registered output beat
//   out_valid  registered output valid
//   out_last   registered end-of-packet
//   out_sel    index of the channel that produced out_data
//   out_ready  downstream accept
// -----------------------------------------------------------------------------
module stream_mux_rr #(
    parameter int  N     = 4,
    parameter int  WIDTH = 8,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_grant;
    logic [SELW-1:0]   r_rr_ptr;

    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              r_out_last;
    logic [SELW-1:0]   r_out_sel;

    logic              w_load_en;
    logic              w_any_valid;
    logic              w_lo_found;
    logic [SELW-1:0]   w_lo_idx;
    logic              w_hi_found;
    logic [SELW-1:0]   w_hi_idx;
    logic [SELW-1:0]   w_arb_idx;
    logic [SELW-1:0]   w_sel;
    logic              w_sel_ready;
    logic              w_beat_valid;
    logic              w_beat_last;
    logic [WIDTH-1:0]  w_beat_data;
    logic              w_accept;
    logic [N-1:0]      w_in_ready;

    assign w_load_en   = ~r_out_valid | out_ready;
    assign w_any_valid = |in_valid;

    // Arbiter. Scanning downward leaves the lowest matching index in place.
    // w_lo_* is the lowest valid channel overall; w_hi_* the lowest valid
    // channel above rr_ptr. Round-robin takes w_hi_* and falls back to
    // w_lo_* when nothing above the pointer is valid (wrap-around).
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = SELW'(k);
                if (SELW'(k) > r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = SELW'(k);
                end
            end
        end
        if (mode && w_hi_found) begin
            w_arb_idx = w_hi_idx;
        end else begin
            w_arb_idx = w_lo_idx;
        end
    end

    // Channel steering: a locked packet keeps its channel; otherwise the
    // arbiter result is used.
    always_comb begin
        w_sel        = (r_state == ST_LOCKED) ? r_grant : w_arb_idx;
        w_sel_ready  = w_load_en & ((r_state == ST_LOCKED) | w_any_valid);
        w_beat_valid = 1'b0;
        w_beat_last  = 1'b0;
        w_beat_data  = '0;
        w_in_ready   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel == SELW'(k)) begin
                w_beat_valid  = in_valid[k];
                w_beat_last   = in_last[k];
                w_beat_data   = in_data[k*WIDTH +: WIDTH];
                w_in_ready[k] = w_sel_ready;
            end
        end
        w_accept = w_load_en & w_beat_valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_beat_last) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_accept && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The pointer starts at N-1 so channel 0 wins the first round-robin pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= SELW'(N - 1);
        end else begin
            if (r_state == ST_IDLE && w_accept && !w_beat_last) begin
                r_grant <= w_sel;
            end
            if (w_accept && w_beat_last) begin
                r_rr_ptr <= w_sel;
            end
        end
    end

    // Output stage: data/last/sel hold when no beat is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_load_en) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_beat_data;
                r_out_last <= w_beat_last;
                r_out_sel  <= w_sel;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//   Scoreboard bench for stream_mux_rr (N=4, WIDTH=8). Per-channel producer
//   memories feed the DUT; each test pushes the beats it expects to see, in
//   order, and the output monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SELW  = 2;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_last;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_last;
    logic [SELW-1:0]    out_sel;
    logic               out_ready;

    stream_mux_rr #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [8:0]  ch_mem [N][DEPTH];
    int          ch_rd  [N];
    int          ch_wr  [N];
    logic [N-1:0] gap;
    logic        bp_en;
    int          cyc;
    logic        prev_stall;
    logic [31:0] prev_word;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [SELW-1:0] s, input logic l,
                                       input logic [WIDTH-1:0] d);
        return {8'(s), 7'd0, l, 8'd0, d};
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += ch_wr[k] - ch_rd[k];
        return s;
    endfunction

    task automatic push(input int k, input logic [7:0] d, input logic l);
        ch_mem[k][ch_wr[k]] = {l, d};
        ch_wr[k]++;
    endtask

    task automatic expect_beat(input logic [SELW-1:0] s, input logic l, input logic [7:0] d);
        exp_q.push_back(mk(s, l, d));
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (ch_rd[k] < ch_wr[k] && !gap[k]) begin
                in_valid[k]                = 1'b1;
                in_last[k]                 = ch_mem[k][ch_rd[k]][8];
                in_data[k*WIDTH +: WIDTH]  = ch_mem[k][ch_rd[k]][7:0];
            end else begin
                in_valid[k]                = 1'b0;
                in_last[k]                 = 1'b0;
                in_data[k*WIDTH +: WIDTH]  = '0;
            end
        end
        if (bp_en) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else       out_ready = 1'b1;
    endtask

    // One clock: sample and check at negedge, advance producers after posedge.
    task automatic step();
        logic [N-1:0] acc;
        logic [31:0]  word;
        @(negedge clk);
        acc  = in_valid & in_ready;
        word = mk(out_sel, out_last, out_data);
        check("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
        if (out_valid && !out_ready) check("ready_stall", 32'(in_ready), 32'd0);
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_beat", word, prev_word);
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = word;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", word, 32'hFFFF_FFFF);
            else                   check("beat", word, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) if (acc[k]) ch_rd[k]++;
        drive();
    endtask

    task automatic run(input int budget, output int used);
        used = 0;
        while ((exp_q.size() != 0 || pending() != 0) && used < budget) begin
            step();
            used++;
        end
        check("drain_exp", 32'(exp_q.size()), 32'd0);
        check("drain_in", 32'(pending()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            ch_rd[k] = 0;
            ch_wr[k] = 0;
        end
        gap        = '0;
        bp_en      = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        cyc       = 0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Fixed priority: ch3 waits while ch1 stays valid
        do_reset();
        mode = 1'b0;
        push(1, 8'h11, 1'b1); push(1, 8'h12, 1'b1); push(1, 8'h13, 1'b1);
        push(3, 8'h33, 1'b1);
        expect_beat(1, 1'b1, 8'h11); expect_beat(1, 1'b1, 8'h12);
        expect_beat(1, 1'b1, 8'h13); expect_beat(3, 1'b1, 8'h33);
        drive();
        run(20, used);

        // Round-robin fairness, one beat per cycle
        do_reset();
        mode = 1'b1;
        push(0, 8'h00, 1'b1); push(0, 8'h00, 1'b1);
        push(1, 8'h10, 1'b1); push(1, 8'h10, 1'b1);
        push(2, 8'h20, 1'b1);
        push(3, 8'h30, 1'b1);
        expect_beat(0, 1'b1, 8'h00); expect_beat(1, 1'b1, 8'h10);
        expect_beat(2, 1'b1, 8'h20); expect_beat(3, 1'b1, 8'h30);
        expect_beat(0, 1'b1, 8'h00); expect_beat(1, 1'b1, 8'h10);
        drive();
        run(20, used);
        check("rr_cycles", 32'(used), 32'd7);

        // Packet lock with a valid gap on the granted channel
        do_reset();
        mode = 1'b1;
        push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
        expect_beat(2, 1'b0, 8'hA0); expect_beat(2, 1'b0, 8'hA1);
        expect_beat(2, 1'b1, 8'hA2);
        expect_beat(0, 1'b1, 8'h01); expect_beat(0, 1'b1, 8'h02);
        drive();
        step();
        gap[2] = 1'b1;
        push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
        drive();
        step();
        gap[2] = 1'b0;
        drive();
        run(30, used);

        // Back-pressure with out_ready pattern 1,0,0,1
        do_reset();
        mode  = 1'b0;
        bp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(1, 8'(8'h51 + i), (i == 2 || i == 5));
            expect_beat(1, (i == 2 || i == 5), 8'(8'h51 + i));
        end
        drive();
        run(80, used);

        // Mode change while ch3 holds a packet
        do_reset();
        mode = 1'b1;
        push(0, 8'h0F, 1'b1);
        expect_beat(0, 1'b1, 8'h0F);
        drive();
        run(10, used);
        push(3, 8'h31, 1'b0); push(3, 8'h32, 1'b0); push(3, 8'h33, 1'b1);
        expect_beat(3, 1'b0, 8'h31); expect_beat(3, 1'b0, 8'h32);
        expect_beat(3, 1'b1, 8'h33);
        drive();
        step();
        push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
        push(2, 8'h21, 1'b1);
        mode = 1'b0;
        expect_beat(0, 1'b1, 8'h01); expect_beat(0, 1'b1, 8'h02);
        expect_beat(2, 1'b1, 8'h21);
        drive();
        run(30, used);

        // Asynchronous reset in the middle of a packet
        do_reset();
        mode = 1'b0;
        push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
        expect_beat(0, 1'b0, 8'h71);
        drive();
        step();
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'h00);
        do_reset();
        push(2, 8'h2A, 1'b1);
        expect_beat(2, 1'b1, 8'h2A);
        drive();
        run(10, used);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
